// File: rtl/sram_mem_if.sv
// sram_mem_if: MEM-stage side of the external SRAM data path.
//
// Signals:
//   MEM_R_EN   load request (level, held while ready=0)
//   MEM_W_EN   store request (level, held while ready=0)
//   ALU_res    32-bit byte address from the ALU
//   ST_val     32-bit store data
//   read_data  32-bit load result
//   ready      1 = pipeline may advance
//
// Modports:
//   master  the pipeline MEM stage (drives requests, receives data/ready)
//   slave   the SRAM controller
interface sram_mem_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_res;
    logic [31:0] ST_val;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_res, ST_val,
        input  read_data, ready
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_res, ST_val,
        output read_data, ready
    );
endinterface

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: runs MEM-stage 32-bit loads/stores on a 16-bit
// asynchronous SRAM as two half-word phases (LOW, then HIGH), stalling the
// pipeline through `ready` until the access completes.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   mem         sram_mem_if.slave (MEM_R_EN, MEM_W_EN, ALU_res, ST_val,
//               read_data, ready)
//   SRAM_DQ     16-bit bidirectional SRAM data bus
//   SRAM_ADDR   half-word address {word, phase}
//   SRAM_WE_N   write enable (active low)
//   SRAM_OE_N   output enable (active low)
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  tied low
//
// Optional feature macro: SRAM_LAST_READ_BYPASS_EN
//   When defined, a one-entry buffer of the last completed load lets a
//   repeated load of the same word finish in IDLE with zero stall.
//
// All SRAM pin controls are registered; each phase lasts WAIT_CYCLES cycles
// and in a store the last cycle of a phase keeps WE_N high with data and
// address stable (hold cycle).
module sram_mem_controller #(
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_mem_if.slave              mem,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);
    localparam int WORD_W = SRAM_ADDR_W - 1;
    localparam int CNT_W  = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(WAIT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    is_store_reg;
    logic [WORD_W-1:0]       word_reg;
    logic [15:0]             st_hi_reg;
    logic [31:0]             read_data_reg;
    logic [15:0]             dq_out_reg;
    logic                    dq_oe_reg;
    logic [SRAM_ADDR_W-1:0]  addr_reg;
    logic                    we_n_reg;
    logic                    oe_n_reg;

    logic                    req;
    logic [WORD_W-1:0]       req_word;
    logic                    bypass_hit;
    logic [31:0]             bypass_data;

    assign req      = mem.MEM_R_EN | mem.MEM_W_EN;
    // Out-of-range addresses wrap silently into the SRAM.
    assign req_word = WORD_W'((mem.ALU_res - BASE_ADDR) >> 2);

`ifdef SRAM_LAST_READ_BYPASS_EN
    logic              buf_valid_reg;
    logic [WORD_W-1:0] buf_word_reg;
    logic [31:0]       buf_data_reg;
    logic [31:0]       pend_data_reg;

    // A hit needs a pure load (a simultaneous store wins and must go to SRAM).
    assign bypass_hit  = (state_reg == IDLE) && mem.MEM_R_EN && !mem.MEM_W_EN &&
                         buf_valid_reg && (buf_word_reg == req_word);
    assign bypass_data = buf_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_word_reg  <= '0;
            buf_data_reg  <= '0;
            pend_data_reg <= '0;
        end else begin
            // Full store word is kept so a matching store can refresh the buffer.
            if (state_reg == IDLE && mem.MEM_W_EN) begin
                pend_data_reg <= mem.ST_val;
            end
            if (state_reg == DONE) begin
                if (!is_store_reg) begin
                    buf_valid_reg <= 1'b1;
                    buf_word_reg  <= word_reg;
                    buf_data_reg  <= read_data_reg;
                end else if (buf_word_reg == word_reg) begin
                    buf_data_reg  <= pend_data_reg;
                end
            end
        end
    end
`else
    assign bypass_hit  = 1'b0;
    assign bypass_data = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            is_store_reg  <= 1'b0;
            word_reg      <= '0;
            st_hi_reg     <= '0;
            read_data_reg <= '0;
            dq_out_reg    <= '0;
            dq_oe_reg     <= 1'b0;
            addr_reg      <= '0;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bypass_hit) begin
                        read_data_reg <= bypass_data;
                    end else if (req) begin
                        state_reg    <= LOW;
                        cnt_reg      <= '0;
                        is_store_reg <= mem.MEM_W_EN;
                        word_reg     <= req_word;
                        st_hi_reg    <= mem.ST_val[31:16];
                        addr_reg     <= {req_word, 1'b0};
                        // Pin setup for the first LOW cycle happens here so
                        // the registered outputs are valid when LOW starts.
                        if (mem.MEM_W_EN) begin
                            dq_out_reg <= mem.ST_val[15:0];
                            dq_oe_reg  <= 1'b1;
                            we_n_reg   <= 1'b0;
                            oe_n_reg   <= 1'b1;
                        end else begin
                            dq_oe_reg  <= 1'b0;
                            we_n_reg   <= 1'b1;
                            oe_n_reg   <= 1'b0;
                        end
                    end
                end
                LOW, HIGH: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (state_reg == LOW) begin
                            if (!is_store_reg) begin
                                read_data_reg[15:0] <= SRAM_DQ;
                            end
                            state_reg <= HIGH;
                            addr_reg  <= {word_reg, 1'b1};
                            if (is_store_reg) begin
                                dq_out_reg <= st_hi_reg;
                                we_n_reg   <= 1'b0;
                            end
                        end else begin
                            if (!is_store_reg) begin
                                read_data_reg[31:16] <= SRAM_DQ;
                            end
                            state_reg <= DONE;
                            // Bus released and OE re-enabled on the same edge,
                            // so DQ is never driven while OE_N is low.
                            we_n_reg  <= 1'b1;
                            dq_oe_reg <= 1'b0;
                            oe_n_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        // Next cycle is the last of the phase: release WE_N
                        // while data and address stay put.
                        if (cnt_reg == CNT_HOLD) begin
                            we_n_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem.ready     = ~req | (state_reg == DONE) | bypass_hit;
    assign mem.read_data = bypass_hit ? bypass_data : read_data_reg;

    assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'bz;
    assign SRAM_ADDR = addr_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: randomized, self-checking bench for
// sram_mem_controller with a pin-level async SRAM model and a word-level
// reference memory. Builds with or without SRAM_LAST_READ_BYPASS_EN.
module tb_sram_mem_controller;
    localparam int ADDR_W = 18;
    localparam int WAITC  = 2;
    localparam int FULL_STALL = 2 * WAITC + 1;
`ifdef SRAM_LAST_READ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    wire  [15:0]       SRAM_DQ;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    sram_mem_if bus();

    sram_mem_controller #(
        .SRAM_ADDR_W(ADDR_W),
        .WAIT_CYCLES(WAITC),
        .BASE_ADDR(32'd1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem(bus.slave),
        .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N),
        .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- pin-level SRAM model ----------------
    logic [15:0] sram_cells [0:(1<<ADDR_W)-1];
    int we_lo_cnt = 0;
    int we_hi_cnt = 0;
    int overlap_cnt = 0;

    function automatic logic [15:0] init_cell(input int a);
        return 16'((a * 40503) ^ 32'h0000C3A5);
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram_cells[i] = init_cell(i);
    end

    assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? sram_cells[SRAM_ADDR] : 16'bz;

    always @(negedge clk) begin
        if (!SRAM_WE_N) begin
            sram_cells[SRAM_ADDR] <= SRAM_DQ;
            if (SRAM_ADDR[0]) we_hi_cnt++;
            else we_lo_cnt++;
        end
        if (dut.dq_oe_reg && !SRAM_OE_N) overlap_cnt++;
    end

    // ---------------- word-level reference model ----------------
    logic [31:0] ref_mem [int];
    bit          last_valid = 1'b0;
    int          last_word  = 0;
    logic [31:0] exp_rd     = 32'd0;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off / 32'd4) % 32'd131072);
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] v, output int exp_stall,
                              output logic [31:0] exp_rdata);
        int wd;
        wd = word_of(a);
        exp_stall = 0;
        if (w) begin
            ref_mem[wd] = v;
            exp_stall = FULL_STALL;
        end else if (r) begin
            exp_rd = ref_mem.exists(wd) ? ref_mem[wd]
                                        : {init_cell(2 * wd + 1), init_cell(2 * wd)};
            exp_stall = (BYPASS && last_valid && last_word == wd) ? 0 : FULL_STALL;
            last_valid = 1'b1;
            last_word  = wd;
        end
        exp_rdata = exp_rd;
    endtask

    task automatic model_reset();
        exp_rd = 32'd0;
        last_valid = 1'b0;
    endtask

    // Drives one request and waits (bounded) for ready; returns observations.
    task automatic run_access(input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] v, output int stall,
                              output logic [31:0] rd, output bit timed_out);
        @(posedge clk); #1;
        we_lo_cnt = 0;
        we_hi_cnt = 0;
        bus.MEM_R_EN = r;
        bus.MEM_W_EN = w;
        bus.ALU_res  = a;
        bus.ST_val   = v;
        stall = 0;
        rd = 32'd0;
        timed_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                rd = bus.read_data;
                timed_out = 1'b0;
                break;
            end
            stall++;
        end
        $display("access r=%0d w=%0d addr=%0d st=%h stall=%0d rd=%h",
                 r, w, a, v, stall, rd);
        @(posedge clk); #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.ALU_res  = 32'd0;
        bus.ST_val   = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++;
        if (bus.read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", bus.read_data); end
        checks++;
        if ({SRAM_WE_N, SRAM_OE_N} !== 2'b10) begin errors++; $display("FAIL reset_we_oe got=%b exp=10", {SRAM_WE_N, SRAM_OE_N}); end
        checks++;
        if (SRAM_ADDR !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", SRAM_ADDR); end
        checks++;
        if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b000) begin errors++; $display("FAIL reset_ties got=%b exp=000", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}); end
    endtask

    task automatic test_store_basic();
        int st, es; logic [31:0] rd, er; bit to;
        model_step(1'b0, 1'b1, 32'd1024, 32'h0000060A, es, er);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0000060A, st, rd, to);
        checks++;
        if (to) begin errors++; $display("FAIL store_basic_timeout got=timeout exp=ready"); end
        checks++;
        if (st != es) begin errors++; $display("FAIL store_basic_stall got=%0d exp=%0d", st, es); end
        checks++;
        if ({sram_cells[1], sram_cells[0]} !== 32'h0000060A) begin errors++; $display("FAIL store_basic_cells got=%h exp=0000060a", {sram_cells[1], sram_cells[0]}); end
        checks++;
        if (we_lo_cnt != WAITC - 1 || we_hi_cnt != WAITC - 1) begin errors++; $display("FAIL store_basic_we_low got=%0d/%0d exp=%0d/%0d", we_lo_cnt, we_hi_cnt, WAITC - 1, WAITC - 1); end
    endtask

    task automatic test_store_load();
        int st, es; logic [31:0] rd, er; bit to;
        model_step(1'b0, 1'b1, 32'd1044, 32'hFFFFE7D8, es, er);
        run_access(1'b0, 1'b1, 32'd1044, 32'hFFFFE7D8, st, rd, to);
        checks++;
        if ({sram_cells[11], sram_cells[10]} !== 32'hFFFFE7D8) begin errors++; $display("FAIL store_load_cells got=%h exp=ffffe7d8", {sram_cells[11], sram_cells[10]}); end
        model_step(1'b1, 1'b0, 32'd1044, 32'd0, es, er);
        run_access(1'b1, 1'b0, 32'd1044, 32'd0, st, rd, to);
        checks++;
        if (to || st != es) begin errors++; $display("FAIL store_load_stall got=%0d exp=%0d", st, es); end
        checks++;
        if (rd !== er) begin errors++; $display("FAIL store_load_data got=%h exp=%h", rd, er); end
        model_step(1'b0, 1'b1, 32'd1200, 32'h12345678, es, er);
        run_access(1'b0, 1'b1, 32'd1200, 32'h12345678, st, rd, to);
        @(negedge clk);
        checks++;
        if (bus.read_data !== er) begin errors++; $display("FAIL store_keeps_read_data got=%h exp=%h", bus.read_data, er); end
    endtask

    task automatic test_unwritten_load();
        int st, es; logic [31:0] rd, er; bit to;
        model_step(1'b1, 1'b0, 32'd1544, 32'd0, es, er);
        run_access(1'b1, 1'b0, 32'd1544, 32'd0, st, rd, to);
        checks++;
        if (to || st != es) begin errors++; $display("FAIL unwritten_stall got=%0d exp=%0d", st, es); end
        checks++;
        if (rd !== er) begin errors++; $display("FAIL unwritten_data got=%h exp=%h", rd, er); end
    endtask

    task automatic test_both_enables();
        int st, es; logic [31:0] rd, er; bit to;
        model_step(1'b1, 1'b1, 32'd1028, 32'd7, es, er);
        run_access(1'b1, 1'b1, 32'd1028, 32'd7, st, rd, to);
        checks++;
        if (to || st != es) begin errors++; $display("FAIL both_stall got=%0d exp=%0d", st, es); end
        checks++;
        if ({sram_cells[3], sram_cells[2]} !== 32'd7) begin errors++; $display("FAIL both_cells got=%h exp=00000007", {sram_cells[3], sram_cells[2]}); end
        checks++;
        if (rd !== er) begin errors++; $display("FAIL both_read_data got=%h exp=%h", rd, er); end
    endtask

    task automatic test_repeat_load();
        int st, es; logic [31:0] rd, er; bit to;
        logic [31:0] first;
        model_step(1'b1, 1'b0, 32'd1024, 32'd0, es, er);
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, st, rd, to);
        first = rd;
        model_step(1'b1, 1'b0, 32'd1024, 32'd0, es, er);
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, st, rd, to);
        checks++;
        if (to || st != es) begin errors++; $display("FAIL repeat_load_stall got=%0d exp=%0d", st, es); end
        checks++;
        if (rd !== first || rd !== er) begin errors++; $display("FAIL repeat_load_data got=%h exp=%h", rd, er); end
        model_step(1'b0, 1'b1, 32'd1024, 32'd5, es, er);
        run_access(1'b0, 1'b1, 32'd1024, 32'd5, st, rd, to);
        model_step(1'b1, 1'b0, 32'd1024, 32'd0, es, er);
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, st, rd, to);
        checks++;
        if (to || st != es) begin errors++; $display("FAIL load_after_store_stall got=%0d exp=%0d", st, es); end
        checks++;
        if (rd !== er) begin errors++; $display("FAIL load_after_store_data got=%h exp=%h", rd, er); end
    endtask

    task automatic test_random();
        int st, es; logic [31:0] rd, er, a, v; bit to, r, w;
        int op, wd;
        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 4));
            r  = (op != 1);
            w  = (op == 1) || (op == 4);
            wd = int'($urandom_range(0, 15));
            a  = 32'd1024 + 32'(wd * 4) + 32'($urandom_range(0, 3));
            v  = $urandom;
            model_step(r, w, a, v, es, er);
            run_access(r, w, a, v, st, rd, to);
            checks++;
            if (to || st != es) begin errors++; $display("FAIL random_stall n=%0d got=%0d exp=%0d", n, st, es); end
            checks++;
            if (rd !== er) begin errors++; $display("FAIL random_read_data n=%0d got=%h exp=%h", n, rd, er); end
            if (w) begin
                checks++;
                if ({sram_cells[2 * wd + 1], sram_cells[2 * wd]} !== v) begin errors++; $display("FAIL random_cells n=%0d got=%h exp=%h", n, {sram_cells[2 * wd + 1], sram_cells[2 * wd]}, v); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int st, es; logic [31:0] rd, er; bit to;
        int reload_word;
        reload_word = last_word;
        @(posedge clk); #1;
        bus.MEM_W_EN = 1'b1;
        bus.MEM_R_EN = 1'b0;
        bus.ALU_res  = 32'd1024 + 32'd400;
        bus.ST_val   = $urandom;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL mid_hold_we got=%b exp=1", SRAM_WE_N); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_reset_idle_ready got=%b exp=0", bus.ready); end
        checks++;
        if (SRAM_WE_N !== 1'b1 || dut.dq_oe_reg !== 1'b0) begin errors++; $display("FAIL mid_reset_pins got=we%b/dq%b exp=we1/dq0", SRAM_WE_N, dut.dq_oe_reg); end
        checks++;
        if (bus.read_data !== 32'd0) begin errors++; $display("FAIL mid_reset_read_data got=%h exp=0", bus.read_data); end
        #1 bus.MEM_W_EN = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready_drop got=%b exp=1", bus.ready); end
        model_step(1'b1, 1'b0, 32'd1024 + 32'(reload_word * 4), 32'd0, es, er);
        run_access(1'b1, 1'b0, 32'd1024 + 32'(reload_word * 4), 32'd0, st, rd, to);
        checks++;
        if (to || st != es) begin errors++; $display("FAIL post_reset_load_stall got=%0d exp=%0d", st, es); end
        checks++;
        if (rd !== er) begin errors++; $display("FAIL post_reset_load_data got=%h exp=%h", rd, er); end
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL dq_oe_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_store_basic();
        test_store_load();
        test_unwritten_load();
        test_both_enables();
        test_repeat_load();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences the MEM-stage data access of the pipelined MIPS core onto the board's external 16-bit asynchronous SRAM.
- Each 32-bit load or store is split into two half-word SRAM cycles.
- Holds `ready` low to freeze the pipeline until the access completes.
- Sits between the MEM stage (address = ALU result, store value) and the SRAM pins. Replaces the single-cycle data memory.

Parameters:
- SRAM_ADDR_W, 18, SRAM half-word address width.
- WAIT_CYCLES, 2, cycles per half-word phase; minimum 2.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- MEM_R_EN  in  1  load request, level, held while ready=0.
- MEM_W_EN  in  1  store request, level, held while ready=0.
- ALU_res  in  32  byte address.
- ST_val  in  32  store data.
- read_data  out  32  load result.
- ready  out  1  1 = pipeline may advance.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM half-word address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0 (chip and both bytes always enabled).

Behaviour:

Reset (synchronous, active-high; also applies mid-access):
- state=IDLE, read_data=0, SRAM_WE_N=1, SRAM_OE_N=0, SRAM_DQ=Z, SRAM_ADDR=0.
- Any in-flight access is abandoned.
- ready follows its combinational rule.

Address translation:
- word = (ALU_res - BASE_ADDR) >> 2, truncated to SRAM_ADDR_W-1 bits (wraps silently; no range check).
- Low phase: SRAM_ADDR = {word,0}. High phase: SRAM_ADDR = {word,1}.

Request decoding:
- req = MEM_R_EN | MEM_W_EN.
- If both are asserted, the store wins. The load is ignored and read_data is not updated.

ready:
- ready = ~req | (state==DONE). Combinational.

States:
- IDLE:
  - req=1 → LOW. Latch op, word and ST_val.
  - Otherwise remain in IDLE; SRAM_WE_N=1, SRAM_DQ=Z.
- LOW: WAIT_CYCLES cycles, counted by an internal counter.
  - Store: SRAM_DQ=ST_val[15:0]; SRAM_OE_N=1; SRAM_WE_N=0 in every cycle except the last of the phase, which is the hold cycle.
  - Load: SRAM_DQ=Z; SRAM_OE_N=0; read_data[15:0] captured from SRAM_DQ in the last cycle.
  - → HIGH.
- HIGH: same as LOW, but uses ST_val[31:16] / read_data[31:16].
  - → DONE.
- DONE: one cycle. ready=1, SRAM_WE_N=1, SRAM_DQ=Z.
  - → IDLE unconditionally, so the next instruction's request is seen in IDLE.

Timing:
- With a request first seen in cycle 0 (IDLE): ready=0 in cycles 0..2*WAIT_CYCLES; ready=1 in cycle 2*WAIT_CYCLES+1 (DONE).
- Default parameters: 5 stall cycles.

Other rules:
- read_data holds its last load value through stores and idle cycles.
- A request dropped mid-access (not legal pipeline behaviour) still completes its SRAM cycles. ready is then 1 because req=0.
- SRAM_DQ is driven only in store LOW/HIGH phases; it is never driven at the same time as SRAM_OE_N=0.

Optional Feature:
- Macro: SRAM_LAST_READ_BYPASS_EN.
- When defined:
  - A one-entry buffer holds {valid, word, data} of the last completed load.
  - A load in IDLE whose word matches while valid=1 → ready=1 in the same cycle, read_data=buffered data, no SRAM cycle, state stays IDLE.
  - A store to the matching word updates the buffer data at DONE.
  - Reset clears valid.
- When undefined: every load takes the full 2*WAIT_CYCLES+1 cycle sequence.

Test Plan:
- Store ALU_res=1024, ST_val=1546 (0x0000060A):
  - SRAM_ADDR 0 gets 0x060A, SRAM_ADDR 1 gets 0x0000.
  - SRAM_WE_N low exactly 1 cycle per phase.
  - ready low 5 cycles, high in the 6th.
- Store 0xFFFFE7D8 to 1044, then load 1044:
  - Store uses SRAM_ADDR 10/11.
  - Load returns read_data=0xFFFFE7D8 in the DONE cycle.
  - read_data is unchanged by a following store.
- Load from 1024+520 with an unwritten SRAM model (X/random) → completes in 6 cycles; read_data equals the model's contents at SRAM_ADDR 260/261.
- MEM_R_EN=MEM_W_EN=1, ALU_res=1028, ST_val=7:
  - Store performed (SRAM_ADDR 2 gets 7, SRAM_ADDR 3 gets 0).
  - read_data unchanged.
- rst asserted in 2nd cycle of HIGH phase of a store:
  - Next cycle: state IDLE, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
  - ready=1 once requests drop.
- With SRAM_LAST_READ_BYPASS_EN: two consecutive loads of 1024 → second has ready=1 in its first cycle with the same data; after a store of 5 to 1024, the next load returns 5 with zero stall.
